switch_event_debounce: RTL and testbench

// - Upstream input-conditioning stage between a raw push-button pin and the event counters

---
 rtl/switch_event_debounce.sv | 159 +++++++++++++++
 tb/tb_switch_event_debounce.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/switch_event_debounce.sv
// Push-button conditioner: 2-FF synchroniser, debounce filter, registered press/release strobes.
// Auto-repeat of press strobes during a long hold is compiled in only when SWITCH_REPEAT_EN is defined.
module switch_event_debounce #(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int HOLD_LIMIT     = 12500000,
  parameter int REPEAT_LIMIT   = 2500000
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_switch,
  output logic o_switch,
  output logic o_press,
  output logic o_release,
  output logic o_repeat
);

  localparam int MAX_LIMIT =
    (DEBOUNCE_LIMIT > HOLD_LIMIT)
      ? ((DEBOUNCE_LIMIT > REPEAT_LIMIT) ? DEBOUNCE_LIMIT : REPEAT_LIMIT)
      : ((HOLD_LIMIT > REPEAT_LIMIT) ? HOLD_LIMIT : REPEAT_LIMIT);
  localparam int CW = $clog2(MAX_LIMIT + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_LIMIT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } state_e;

  state_e          state_q;
  logic            sync1_q;
  logic            sync2_q;
  logic            press_q;
  logic            release_q;
  logic [CW-1:0]   db_cnt_q;
  logic [CW-1:0]   db_cnt_d;
  logic            accept_d;
  logic            level;

  // The FSM state doubles as the debounced level: any non-IDLE state means pressed.
  assign level     = (state_q != IDLE);
  assign o_switch  = level;
  assign o_press   = press_q;
  assign o_release = release_q;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= i_switch;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    accept_d = 1'b0;
    db_cnt_d = db_cnt_q;
    if (sync2_q == level) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      accept_d = 1'b1;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      db_cnt_q <= '0;
    end else begin
      db_cnt_q <= db_cnt_d;
    end
  end

`ifdef SWITCH_REPEAT_EN
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_LIMIT - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_LIMIT - 1);

  logic [CW-1:0] hold_cnt_q;
  logic [CW-1:0] rep_cnt_q;
  logic          repeat_q;

  assign o_repeat = repeat_q;

  // An accepted level change is handled first, so a release always beats a hold/repeat expiry.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q    <= IDLE;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      repeat_q   <= 1'b0;
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      if (accept_d) begin
        if (sync2_q) begin
          state_q    <= HELD;
          press_q    <= 1'b1;
          hold_cnt_q <= '0;
        end else begin
          state_q   <= IDLE;
          release_q <= 1'b1;
          repeat_q  <= 1'b0;
        end
      end else begin
        case (state_q)
          HELD: begin
            if (hold_cnt_q == HOLD_LAST) begin
              state_q    <= REPEAT;
              press_q    <= 1'b1;
              repeat_q   <= 1'b1;
              rep_cnt_q  <= '0;
              hold_cnt_q <= '0;
            end else begin
              hold_cnt_q <= hold_cnt_q + 1'b1;
            end
          end
          REPEAT: begin
            if (rep_cnt_q == REP_LAST) begin
              press_q   <= 1'b1;
              rep_cnt_q <= '0;
            end else begin
              rep_cnt_q <= rep_cnt_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
`else
  assign o_repeat = 1'b0;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= IDLE;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      if (accept_d) begin
        if (sync2_q) begin
          state_q <= HELD;
          press_q <= 1'b1;
        end else begin
          state_q   <= IDLE;
          release_q <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_switch_event_debounce.sv
// Scoreboarded bench: a sliding-window reference model predicts every output cycle from the input history.
module tb_switch_event_debounce;
  localparam int DB   = 4;
  localparam int HOLD = 20;
  localparam int REP  = 8;
  localparam int MAXC = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sw  = 1'b0;
  logic o_sw, o_pr, o_rel, o_rep;

  always #5 clk = ~clk;

  switch_event_debounce #(
    .DEBOUNCE_LIMIT(DB),
    .HOLD_LIMIT(HOLD),
    .REPEAT_LIMIT(REP)
  ) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .i_switch(sw),
    .o_switch(o_sw),
    .o_press(o_pr),
    .o_release(o_rel),
    .o_repeat(o_rep)
  );

  logic [3:0] exp_q[$];
  int checks = 0;
  int passed = 0;
  int shown  = 0;
  int cyc    = 0;

  // Reference state: value captured by the first sync stage at each edge, plus the debounced level.
  bit hist [0:MAXC-1];
  int t       = 0;
  bit level   = 1'b0;
  int press_t = 0;

  task automatic step(input bit r, input bit v);
    bit press, rel, rpt, flip;
    int d;
    @(negedge clk);
    rst = r;
    sw  = v;
    press = 1'b0;
    rel   = 1'b0;
    rpt   = 1'b0;
    flip  = 1'b0;
    if (t >= MAXC) begin
      $display("FAIL model_overflow: cycle %0d exceeds history %0d", t, MAXC);
      $fatal(1);
    end
    if (r) begin
      hist[t] = 1'b0;
      if (t > 0) hist[t-1] = 1'b0;
      level = 1'b0;
    end else begin
      hist[t] = v;
      // Level flips once the last DB synchronised samples all disagree with it.
      if (t >= DB + 1) begin
        flip = 1'b1;
        for (int k = 2; k <= DB + 1; k++)
          if (hist[t-k] == level) flip = 1'b0;
      end
      if (flip) begin
        level = !level;
        if (level) begin
          press   = 1'b1;
          press_t = t;
        end else begin
          rel = 1'b1;
        end
      end
`ifdef SWITCH_REPEAT_EN
      else if (level) begin
        d = t - press_t;
        if (d >= HOLD && ((d - HOLD) % REP) == 0) press = 1'b1;
      end
      rpt = level && ((t - press_t) >= HOLD);
`endif
    end
    exp_q.push_back({level, press, rel, rpt});
    t++;
  endtask

  task automatic hold_lvl(input bit v, input int n);
    repeat (n) step(1'b0, v);
  endtask

  // Monitor: every cycle the DUT presents a fresh output vector, compare it to the oldest prediction.
  initial begin
    logic [3:0] e, got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {o_sw, o_pr, o_rel, o_rep};
        checks++;
        if (got === e) begin
          passed++;
        end else if (shown < 25) begin
          shown++;
          $display("FAIL outputs@%0d: got switch/press/release/repeat=%b required %b", cyc, got, e);
        end
        cyc++;
      end
    end
  end

  initial begin
    int lv, run;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    hold_lvl(1'b0, 10);
    // Clean press, long hold into repeat, release.
    hold_lvl(1'b1, 90);
    hold_lvl(1'b0, 20);
    // Short glitch from idle.
    hold_lvl(1'b1, 3);
    hold_lvl(1'b0, 15);
    // Bounce then settle high.
    for (int i = 0; i < 6; i++) begin
      hold_lvl(1'b1, 2);
      hold_lvl(1'b0, 2);
    end
    hold_lvl(1'b1, 40);
    // Release glitch while held.
    hold_lvl(1'b0, 3);
    hold_lvl(1'b1, 10);
    hold_lvl(1'b0, 20);
    // Reset mid-hold with the switch still pressed.
    hold_lvl(1'b1, 40);
    step(1'b1, 1'b1);
    hold_lvl(1'b1, 30);
    hold_lvl(1'b0, 20);
    // Release timed to coincide with repeat expiries.
    hold_lvl(1'b1, 6 + HOLD + REP - 6);
    hold_lvl(1'b0, 20);
    for (int s = 0; s < 80; s++) begin
      lv  = $urandom_range(0, 1);
      run = ($urandom_range(0, 3) == 0) ? $urandom_range(25, 70) : $urandom_range(1, 8);
      hold_lvl(lv[0], run);
    end
    hold_lvl(1'b0, 20);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain: %0d predictions left, required 0", exp_q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
